// File: rtl/otter_bp_pkg.sv
// Shared types for the OTTER branch predictor: counter states, BTB entry, counter update.
// Optional statistics counters are enabled by defining OTTER_BP_STATS_EN.
package otter_bp_pkg;

  typedef enum logic [1:0] {
    STRONG_NT = 2'b00,
    WEAK_NT   = 2'b01,
    WEAK_T    = 2'b10,
    STRONG_T  = 2'b11
  } ctr_e;

  typedef struct packed {
    logic        valid;
    ctr_e        ctr;
    logic [31:0] target;
  } btb_entry_t;

  localparam logic [31:0] PC_STEP = 32'd4;

  function automatic ctr_e sat_update(input ctr_e ctr, input logic taken);
    ctr_e res;
    res = ctr;
    if (taken) begin
      if (ctr != STRONG_T) res = ctr_e'(ctr + 2'd1);
    end else begin
      if (ctr != STRONG_NT) res = ctr_e'(ctr - 2'd1);
    end
    return res;
  endfunction

endpackage

// File: rtl/otter_bp_stats.sv
// Resolved-update and mispredict counters for the OTTER branch predictor.
// Only instantiated when OTTER_BP_STATS_EN is defined.
module otter_bp_stats
  import otter_bp_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        branch_i,
  input  logic        mispredict_i,
  output logic [31:0] branches_o,
  output logic [31:0] mispredicts_o
);

  logic [31:0] br_q, br_d;
  logic [31:0] mp_q, mp_d;

  always_comb begin
    br_d = br_q;
    mp_d = mp_q;
    if (branch_i)     br_d = br_q + 32'd1;
    if (mispredict_i) mp_d = mp_q + 32'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      br_q <= '0;
      mp_q <= '0;
    end else begin
      br_q <= br_d;
      mp_q <= mp_d;
    end
  end

  assign branches_o    = br_q;
  assign mispredicts_o = mp_q;

endmodule

// File: rtl/otter_branch_predictor.sv
// Direct-mapped BTB with 2-bit counters: Fetch lookup, Execute training and mispredict detect.
// Define OTTER_BP_STATS_EN to build the update/mispredict statistics counters.
module otter_branch_predictor
  import otter_bp_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int TAG_W   = 8
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        BP_CLEAR,
  input  logic [31:0] PC_F,
  output logic        PRED_TAKEN_F,
  output logic [31:0] PRED_NEXT_PC_F,
  input  logic        UPD_VALID_E,
  input  logic        UPD_IS_JUMP_E,
  input  logic [31:0] UPD_PC_E,
  input  logic        UPD_TAKEN_E,
  input  logic [31:0] UPD_TARGET_E,
  input  logic        UPD_PRED_TAKEN_E,
  input  logic [31:0] UPD_PRED_NEXT_PC_E,
  output logic        MISPREDICT_E,
  output logic [31:0] REDIRECT_PC_E,
  output logic [31:0] STAT_BRANCHES,
  output logic [31:0] STAT_MISPREDICTS
);

  localparam int IDX_W = $clog2(ENTRIES);

  btb_entry_t       tbl_q [ENTRIES];
  logic [TAG_W-1:0] tag_q [ENTRIES];

  logic [IDX_W-1:0] f_idx, u_idx;
  logic [TAG_W-1:0] f_tag, u_tag;
  btb_entry_t       f_ent, u_ent, ent_d;
  logic             f_hit, u_hit, wr_en;
  logic [31:0]      act_next;

  assign f_idx = PC_F[IDX_W+1:2];
  assign f_tag = PC_F[IDX_W+TAG_W+1:IDX_W+2];
  assign f_ent = tbl_q[f_idx];
  assign f_hit = f_ent.valid && (tag_q[f_idx] == f_tag);

  assign PRED_TAKEN_F   = f_hit && f_ent.ctr[1];
  assign PRED_NEXT_PC_F = PRED_TAKEN_F ? f_ent.target : PC_F + PC_STEP;

  assign u_idx = UPD_PC_E[IDX_W+1:2];
  assign u_tag = UPD_PC_E[IDX_W+TAG_W+1:IDX_W+2];
  assign u_ent = tbl_q[u_idx];
  assign u_hit = u_ent.valid && (tag_q[u_idx] == u_tag);

  always_comb begin
    ent_d = u_ent;
    wr_en = 1'b0;
    if (UPD_VALID_E) begin
      if (u_hit) begin
        wr_en = 1'b1;
        if (UPD_IS_JUMP_E) begin
          ent_d.ctr    = STRONG_T;
          ent_d.target = UPD_TARGET_E;
        end else begin
          ent_d.ctr = sat_update(u_ent.ctr, UPD_TAKEN_E);
          if (UPD_TAKEN_E) ent_d.target = UPD_TARGET_E;
        end
      end else if (UPD_TAKEN_E) begin
        wr_en        = 1'b1;
        ent_d.valid  = 1'b1;
        ent_d.target = UPD_TARGET_E;
        ent_d.ctr    = UPD_IS_JUMP_E ? STRONG_T : WEAK_T;
      end
    end
  end

  // Clear drops valid bits only; counters and targets survive.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < ENTRIES; i++) begin
        tbl_q[i] <= '{valid: 1'b0, ctr: WEAK_NT, target: '0};
        tag_q[i] <= '0;
      end
    end else if (BP_CLEAR) begin
      for (int i = 0; i < ENTRIES; i++) begin
        tbl_q[i].valid <= 1'b0;
      end
    end else if (wr_en) begin
      tbl_q[u_idx] <= ent_d;
      tag_q[u_idx] <= u_tag;
    end
  end

  assign act_next      = UPD_TAKEN_E ? UPD_TARGET_E : UPD_PC_E + PC_STEP;
  assign REDIRECT_PC_E = act_next;
  assign MISPREDICT_E  = UPD_VALID_E && (act_next != UPD_PRED_NEXT_PC_E);

`ifdef OTTER_BP_STATS_EN
  otter_bp_stats u_stats (
    .clk_i         (CLK),
    .rst_i         (RESET),
    .branch_i      (UPD_VALID_E),
    .mispredict_i  (MISPREDICT_E),
    .branches_o    (STAT_BRANCHES),
    .mispredicts_o (STAT_MISPREDICTS)
  );
`else
  assign STAT_BRANCHES    = '0;
  assign STAT_MISPREDICTS = '0;
`endif

  logic unused_ok;
  assign unused_ok = ^{PC_F, UPD_PC_E, UPD_PRED_TAKEN_E};

endmodule

// File: tb/tb_otter_branch_predictor.sv
// Directed bench for otter_branch_predictor; stats checks follow OTTER_BP_STATS_EN.
// Inputs change 1ns after the rising edge, outputs are sampled before the next edge.
module tb_otter_branch_predictor;

  logic        CLK = 1'b0;
  logic        RESET, BP_CLEAR;
  logic [31:0] PC_F;
  logic        PRED_TAKEN_F;
  logic [31:0] PRED_NEXT_PC_F;
  logic        UPD_VALID_E, UPD_IS_JUMP_E, UPD_TAKEN_E, UPD_PRED_TAKEN_E;
  logic [31:0] UPD_PC_E, UPD_TARGET_E, UPD_PRED_NEXT_PC_E;
  logic        MISPREDICT_E;
  logic [31:0] REDIRECT_PC_E, STAT_BRANCHES, STAT_MISPREDICTS;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_br = 0;
  logic [31:0] exp_mp = 0;

  always #5 CLK = ~CLK;

  otter_branch_predictor dut (
    .CLK                (CLK),
    .RESET              (RESET),
    .BP_CLEAR           (BP_CLEAR),
    .PC_F               (PC_F),
    .PRED_TAKEN_F       (PRED_TAKEN_F),
    .PRED_NEXT_PC_F     (PRED_NEXT_PC_F),
    .UPD_VALID_E        (UPD_VALID_E),
    .UPD_IS_JUMP_E      (UPD_IS_JUMP_E),
    .UPD_PC_E           (UPD_PC_E),
    .UPD_TAKEN_E        (UPD_TAKEN_E),
    .UPD_TARGET_E       (UPD_TARGET_E),
    .UPD_PRED_TAKEN_E   (UPD_PRED_TAKEN_E),
    .UPD_PRED_NEXT_PC_E (UPD_PRED_NEXT_PC_E),
    .MISPREDICT_E       (MISPREDICT_E),
    .REDIRECT_PC_E      (REDIRECT_PC_E),
    .STAT_BRANCHES      (STAT_BRANCHES),
    .STAT_MISPREDICTS   (STAT_MISPREDICTS)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    UPD_VALID_E = 1'b0;
    BP_CLEAR    = 1'b0;
  endtask

  task automatic look(input logic [31:0] pc, input logic tk,
                      input logic [31:0] nx, input string tag);
    PC_F = pc;
    #1;
    chk({tag, ".tk"}, {31'b0, PRED_TAKEN_F}, {31'b0, tk});
    chk({tag, ".nx"}, PRED_NEXT_PC_F, nx);
  endtask

  task automatic upd(input logic jmp, input logic [31:0] pc, input logic tk,
                     input logic [31:0] tgt, input logic [31:0] pnx,
                     input logic mis, input logic [31:0] redir,
                     input string tag);
    UPD_VALID_E        = 1'b1;
    UPD_IS_JUMP_E      = jmp;
    UPD_PC_E           = pc;
    UPD_TAKEN_E        = tk;
    UPD_TARGET_E       = tgt;
    UPD_PRED_NEXT_PC_E = pnx;
    UPD_PRED_TAKEN_E   = (pnx != pc + 32'd4);
    #1;
    chk({tag, ".mis"}, {31'b0, MISPREDICT_E}, {31'b0, mis});
    chk({tag, ".redir"}, REDIRECT_PC_E, redir);
    exp_br = exp_br + 32'd1;
    if (mis) exp_mp = exp_mp + 32'd1;
  endtask

  task automatic chk_stats(input string tag);
`ifdef OTTER_BP_STATS_EN
    chk({tag, ".br"}, STAT_BRANCHES, exp_br);
    chk({tag, ".mp"}, STAT_MISPREDICTS, exp_mp);
`else
    chk({tag, ".br"}, STAT_BRANCHES, 32'd0);
    chk({tag, ".mp"}, STAT_MISPREDICTS, 32'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    RESET = 1'b1; BP_CLEAR = 1'b0; PC_F = '0;
    UPD_VALID_E = 1'b0; UPD_IS_JUMP_E = 1'b0; UPD_PC_E = '0;
    UPD_TAKEN_E = 1'b0; UPD_TARGET_E = '0; UPD_PRED_TAKEN_E = 1'b0;
    UPD_PRED_NEXT_PC_E = '0;
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b0;
    exp_br = 0; exp_mp = 0;

    look(32'h100, 1'b0, 32'h104, "rst");
    chk_stats("rst");
    look(32'hFFFF_FFFC, 1'b0, 32'h0, "wrapf");

    // Invalid update with live-looking inputs must not flag
    UPD_TAKEN_E = 1'b1; UPD_TARGET_E = 32'h55; UPD_PRED_NEXT_PC_E = 32'h0;
    #1;
    chk("idle.mis", {31'b0, MISPREDICT_E}, 32'd0);

    upd(1'b0, 32'h100, 1'b1, 32'h80, 32'h104, 1'b1, 32'h80, "t2");
    look(32'h100, 1'b0, 32'h104, "same");
    tick();
    look(32'h100, 1'b1, 32'h80, "t2n");

    upd(1'b0, 32'h100, 1'b0, 32'hDEAD_0000, 32'h80, 1'b1, 32'h104, "nt1");
    tick();
    look(32'h100, 1'b0, 32'h104, "nt1n");
    upd(1'b0, 32'h100, 1'b0, 32'h0, 32'h104, 1'b0, 32'h104, "nt2");
    tick();
    look(32'h100, 1'b0, 32'h104, "nt2n");
    upd(1'b0, 32'h100, 1'b1, 32'h80, 32'h104, 1'b1, 32'h80, "tk1");
    tick();
    look(32'h100, 1'b0, 32'h104, "sat0");
    upd(1'b0, 32'h100, 1'b1, 32'h80, 32'h104, 1'b1, 32'h80, "tk2");
    tick();
    look(32'h100, 1'b1, 32'h80, "tk2n");

    look(32'h140, 1'b0, 32'h144, "alias");
    upd(1'b1, 32'h140, 1'b1, 32'h200, 32'h144, 1'b1, 32'h200, "jal");
    tick();
    look(32'h140, 1'b1, 32'h200, "jaln");
    look(32'h100, 1'b0, 32'h104, "evict");
    upd(1'b0, 32'h140, 1'b0, 32'hBAD0, 32'h200, 1'b1, 32'h144, "ntj");
    tick();
    look(32'h140, 1'b1, 32'h200, "jctr");

    upd(1'b0, 32'hFFFF_FFFC, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, "wrapu");
    tick();
    look(32'hFFFF_FFFC, 1'b0, 32'h0, "wrapl");
    chk_stats("mid");

    BP_CLEAR = 1'b1;
    upd(1'b0, 32'h180, 1'b1, 32'h300, 32'h184, 1'b1, 32'h300, "clr");
    tick();
    look(32'h140, 1'b0, 32'h144, "clr140");
    look(32'h180, 1'b0, 32'h184, "clr180");
    chk_stats("clr");

    RESET = 1'b1;
    upd(1'b1, 32'h1C0, 1'b1, 32'h400, 32'h1C4, 1'b1, 32'h400, "rstu");
    tick();
    RESET = 1'b0;
    exp_br = 0; exp_mp = 0;
    look(32'h1C0, 1'b0, 32'h1C4, "rstl");
    chk_stats("rst2");

    upd(1'b0, 32'h100, 1'b1, 32'h80, 32'h104, 1'b1, 32'h80, "fresh");
    look(32'h100, 1'b0, 32'h104, "fsame");
    tick();
    look(32'h100, 1'b1, 32'h80, "fnext");
    chk_stats("end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
